led_hex_scanner: RTL and testbench
==================================

Name: led_hex_scanner

Overview:
- Downstream consumer of the CPU's 32-bit `led_data` output.
- Latches a display word and time-multiplexes it as 8 hexadecimal digits onto a common-anode 7-segment board (active-low anodes and segments).
- Sits between the `mips` top-level `led_data` port and the board pins, in the same clock domain as the core.

Parameters:
- DATA_WIDTH, 32, width of the display word; must equal 4*DIGITS.
- DIGITS, 8, number of hex digits scanned.
- SCAN_DIV, 100000, clk cycles each digit stays enabled; legal range >= 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; 0 freezes the scan position.
- data_in  input  DATA_WIDTH  word to display (connect to `led_data`).
- data_valid  input  1  capture strobe; 1 at an edge loads data_in into the shadow register.
- an  output  DIGITS  digit enables, active-low, one-hot-low when scanning.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; tied off (always 1).
- digit_idx  output  $clog2(DIGITS)  currently selected digit, for debug and verification.

Behaviour:
- Reset:
  - All state is synchronous to clk; rst has priority over en and data_valid.
  - At a rising edge with rst=1: shadow=0, div_cnt=0, digit_idx=0, an=all 1s, seg=7'h7F, dp=1.
  - Reset mid-scan or mid-capture discards the shadow value and scan position.
- Capture:
  - data_valid=1 at edge N loads shadow<=data_in at N, independent of en.
  - seg reflects the new nibble for the selected digit at edge N+1.
  - Simultaneous data_valid and a digit advance: both take effect at N, and seg at N+1 shows the new shadow's nibble for the new digit.
- Prescaler:
  - div_cnt has width $clog2(SCAN_DIV) and a minimum of 1 bit.
  - With en=1, div_cnt increments each cycle.
  - When div_cnt==SCAN_DIV-1: div_cnt<=0 and digit_idx advances.
  - digit_idx wraps DIGITS-1 -> 0.
  - With SCAN_DIV=1, digit_idx advances every cycle while en=1.
  - en=0 holds both div_cnt and digit_idx; outputs keep driving the current digit.
- Output register (updated every non-reset edge from current state, one-cycle latency):
  - an <= ~(1 << digit_idx).
  - seg <= hex7(shadow[4*digit_idx +: 4]).
  - The first edge after rst deasserts gives an=8'hFE and seg=7'h40 (digit 0, value 0).
- Digit mapping: digit 0 = shadow[3:0] on an[0] (rightmost); digit 7 = shadow[31:28] on an[7].
- hex7 table (active-low):

  | Nibble | seg | Nibble | seg |
  |---|---|---|---|
  | 0 | 40 | 8 | 00 |
  | 1 | 79 | 9 | 10 |
  | 2 | 24 | A | 08 |
  | 3 | 30 | b | 03 |
  | 4 | 19 | C | 46 |
  | 5 | 12 | d | 21 |
  | 6 | 02 | E | 06 |
  | 7 | 78 | F | 0E |

- No X propagation: all outputs are defined after the first reset edge.

Optional Feature:
- Macro: LED_HEX_SCANNER_BLANK_EN.
- Defined:
  - Compute msd = index of the highest nonzero nibble of shadow (0 if shadow==0).
  - Any digit with index > msd drives seg=7'h7F; its an is still asserted, so scan timing is unchanged.
  - Digit 0 is never blanked, so shadow==0 shows a single "0".
  - Same one-cycle latency as the normal path.
- Undefined: all DIGITS digits always display, including leading zeros.

Test Plan:
- Reset, then release (SCAN_DIV=4, en=1, no capture): first edge gives an=FE, seg=40; digit_idx steps every 4 cycles through 0..7 then wraps to 0 after 32 cycles.
- Capture and scan: data_valid=1 with data_in=32'h89AB_CDEF; over one full scan, digits 0..7 show seg=0E,06,21,46,03,08,10,00 on an=FE,FD,FB,F7,EF,DF,BF,7F.
- Scan freeze: en=0 for 20 cycles at digit 3 leaves digit_idx=3, an=F7, div_cnt unchanged; en=1 resumes counting from the held div_cnt.
- Capture on a digit advance: data_valid with 32'h0000_0005 on the same edge digit_idx 7->0 gives seg=12 on an=FE at the next edge.
- Reset mid-scan: rst=1 for one cycle at digit 5 with shadow=32'hFFFF_FFFF gives an=FF, seg=7F; next edge gives an=FE, seg=40.
- Blanking, LED_HEX_SCANNER_BLANK_EN defined: shadow=32'h0000_0A10 gives digits 0..2 = 40,79,08 and digits 3..7 = 7F; shadow=0 gives digit 0 = 40 and all others 7F.

Source files
------------

// File: rtl/led_hex_scanner_if.sv
// Display-side bundle for led_hex_scanner: capture/scan controls in,
// active-low anode/segment drive and debug digit index out.
interface led_hex_scanner_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIGITS     = 8
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic [IW-1:0]         digit_idx;

  modport master (
    output en, data_in, data_valid,
    input  an, seg, dp, digit_idx
  );

  modport slave (
    input  en, data_in, data_valid,
    output an, seg, dp, digit_idx
  );
endinterface

// File: rtl/led_hex_scanner.sv
// Latches a display word and scans it as hex digits onto a common-anode
// 7-segment board. Define LED_HEX_SCANNER_BLANK_EN to blank leading zeros.
module led_hex_scanner #(
  parameter int DATA_WIDTH = 32,
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  led_hex_scanner_if.slave  bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DATA_WIDTH-1:0] shadow;
  logic [CW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [DIGITS-1:0]     an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [3:0]            nib;
  logic [6:0]            seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign nib = shadow[4*idx +: 4];

`ifdef LED_HEX_SCANNER_BLANK_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (shadow[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end

  // Digit 0 is never above msd, so a zero word still shows "0".
  assign seg_d = (idx > msd) ? 7'h7F : hex7(nib);
`else
  assign seg_d = hex7(nib);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      div_cnt <= '0;
      idx     <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      if (bus.data_valid) shadow <= bus.data_in;
      if (bus.en) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      an_q  <= ~(DIGITS'(1) << idx);
      seg_q <= seg_d;
      dp_q  <= 1'b1;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = idx;
endmodule

// File: tb/tb_led_hex_scanner.sv
// Randomized and directed checks of led_hex_scanner against a tick-count
// reference model (SCAN_DIV=4).
module tb_led_hex_scanner;
  localparam int SD = 4;
  localparam int ND = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  led_hex_scanner_if #(.DATA_WIDTH(32), .DIGITS(ND)) bus ();

  led_hex_scanner #(
    .DATA_WIDTH(32),
    .DIGITS    (ND),
    .SCAN_DIV  (SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [31:0] m_shadow = '0;
  int          m_ticks  = 0;

  function automatic int cur_digit();
    return (m_ticks / SD) % ND;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] sh, input int d);
    int nib;
    nib = int'((sh >> (4 * d)) & 32'hF);
`ifdef LED_HEX_SCANNER_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < ND; i++)
        if (((sh >> (4 * i)) & 32'hF) != 0) msd = i;
      if (d > msd) return 7'h7F;
    end
`endif
    return hex_tab[nib];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [31:0] d);
    logic [7:0] ean;
    logic [6:0] eseg;
    @(negedge clk);
    rst            = r;
    bus.en         = e;
    bus.data_valid = v;
    bus.data_in    = d;
    if (r) begin
      ean  = 8'hFF;
      eseg = 7'h7F;
      m_shadow = '0;
      m_ticks  = 0;
    end else begin
      ean  = ~(8'd1 << cur_digit());
      eseg = exp_seg(m_shadow, cur_digit());
      if (v) m_shadow = d;
      if (e) m_ticks++;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(bus.an), 32'(ean));
    chk("seg", 32'(bus.seg), 32'(eseg));
    chk("dp", 32'(bus.dp), 32'd1);
    chk("idx", 32'(bus.digit_idx), 32'(cur_digit()));
  endtask

  task automatic run_to_digit(input int k);
    int n;
    n = 0;
    while (cur_digit() != k && n < 64) begin
      step(0, 1, 0, '0);
      n++;
    end
    chk("reach_digit", 32'(cur_digit()), 32'(k));
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    return w >> (4 * $urandom_range(0, 8));
  endfunction

  initial begin
    bus.en         = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    step(1, 0, 0, '0);
    step(1, 1, 1, 32'hDEAD_BEEF);
    // Idle scan after reset: one full rotation plus wrap.
    for (int i = 0; i < 40; i++) step(0, 1, 0, '0);
    // Capture and full scan.
    step(0, 1, 1, 32'h89AB_CDEF);
    for (int i = 0; i < 40; i++) step(0, 1, 0, '0);
    // Freeze at digit 3.
    run_to_digit(3);
    step(0, 1, 0, '0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, '0);
    // Capture coinciding with the 7 -> 0 advance.
    begin
      int n;
      n = 0;
      while ((m_ticks % (SD * ND)) != (SD * ND - 1) && n < 64) begin
        step(0, 1, 0, '0);
        n++;
      end
      chk("reach_wrap", 32'(m_ticks % (SD * ND)), 32'(SD * ND - 1));
    end
    step(0, 1, 1, 32'h0000_0005);
    step(0, 1, 0, '0);
    // Reset mid-scan with a full shadow.
    step(0, 1, 1, 32'hFFFF_FFFF);
    run_to_digit(5);
    step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    // Leading-zero words.
    step(0, 1, 1, 32'h0000_0A10);
    for (int i = 0; i < 34; i++) step(0, 1, 0, '0);
    step(0, 1, 1, 32'h0000_0000);
    for (int i = 0; i < 34; i++) step(0, 1, 0, '0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) == 0,
           rnd_word());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
